// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive frame shift register.
//   rx_frame_state_t : frame position (data bits, parity bit, stop bits)
//   MAX_DATA_BITS    : largest supported data width
//   cnt_width()      : width of the bit counter for a given data width
package uart_rx_pkg;

  typedef enum logic [1:0] {
    S_DATA   = 2'd0,
    S_PARITY = 2'd1,
    S_STOP   = 2'd2
  } rx_frame_state_t;

  localparam int MAX_DATA_BITS = 9;

  // The counter runs 0..DATA_BITS-1 in the data phase and 0..STOP_BITS-1
  // in the stop phase; the data phase always needs the wider range.
  function automatic int cnt_width(input int data_bits);
    return (data_bits < 2) ? 1 : $clog2(data_bits);
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Up-counter with enable, synchronous clear and a programmable terminal
// value. On an enabled cycle at the terminal value it wraps to 0.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   clear     : synchronous clear (count -> 0), lower priority than rst
//   en        : count enable
//   last      : terminal count value
//   count     : current count
//   at_last   : count equals last
module rx_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         at_last
);

  assign at_last = (count == last);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= at_last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_sr.sv
// Parametrised UART receive shift register. Captures DATA_BITS data bits,
// an optional parity bit and STOP_BITS stop bits, one bit per shift_strobe,
// then latches the completed frame with parity/framing status.
//
// Strobe semantics: shift_strobe is a one-cycle sample enable with no
// back-pressure; every cycle it is high (and clear/rst are low) consumes
// exactly one bit of serial_in. Gaps between strobes hold all state.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear          : abort the partial frame, restart at data bit 0
//   shift_strobe   : sample enable for serial_in
//   serial_in      : synchronised serial line
//   packet_data    : last completed frame's data bits
//   parity_bit     : last completed frame's parity bit (1 without parity)
//   stop_bit       : AND of the last completed frame's stop bits
//   frame_done     : one-cycle pulse when the frame outputs update
//   parity_error   : last frame failed parity (0 without parity)
//   framing_error  : a stop bit of the last frame sampled 0
//   busy           : at least one bit of the current frame captured
module uart_rx_frame_sr
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] packet_data,
  output logic                 parity_bit,
  output logic                 stop_bit,
  output logic                 frame_done,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int CW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_SEL    = (PARITY_ODD != 0);

  rx_frame_state_t        state;
  rx_frame_state_t        next_state;
  logic [CW-1:0]          cnt;
  logic                   at_last;
  logic                   cnt_en;
  logic [CW-1:0]          cnt_last;
  logic                   complete;
  logic                   stb;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   shreg_next;
  logic                   parity_reg;
  logic                   stop_acc;
  logic                   stop_final;
  logic                   data_xor;

  // clear wins over a coincident strobe; rst is handled in the registers.
  assign stb = shift_strobe & ~clear;

  rx_bit_counter #(
    .W (CW)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .en      (cnt_en),
    .last    (cnt_last),
    .count   (cnt),
    .at_last (at_last)
  );

  // Frame position state register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= S_DATA;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, counter control and completion decode.
  always_comb begin
    next_state = state;
    cnt_en     = 1'b0;
    cnt_last   = DATA_LAST;
    complete   = 1'b0;
    case (state)
      S_DATA: begin
        cnt_en = stb;
        if (stb && at_last) begin
          next_state = HAS_PARITY ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (stb) begin
          next_state = S_STOP;
        end
      end
      S_STOP: begin
        cnt_last = STOP_LAST;
        cnt_en   = stb;
        if (stb && at_last) begin
          next_state = S_DATA;
          complete   = 1'b1;
        end
      end
      default: begin
        next_state = S_DATA;
      end
    endcase
  end

  // LSB-first shifts right so the first bit ends up in bit 0 after
  // DATA_BITS strobes; MSB-first shifts left so it ends up in the MSB.
  always_comb begin
    if (LSB_FIRST != 0) begin
      shreg_next = {serial_in, shreg[DATA_BITS-1:1]};
    end else begin
      shreg_next = {shreg[DATA_BITS-2:0], serial_in};
    end
  end

  assign stop_final = stop_acc & serial_in;
  assign data_xor   = ^shreg;

  // Datapath and latched frame outputs. stop_acc stays at 1 outside the
  // stop phase, so it is already preset when the stop phase is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg         <= '1;
      parity_reg    <= 1'b1;
      stop_acc      <= 1'b1;
      packet_data   <= '1;
      parity_bit    <= 1'b1;
      stop_bit      <= 1'b1;
      frame_done    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        shreg      <= '1;
        parity_reg <= 1'b1;
        stop_acc   <= 1'b1;
      end else if (stb) begin
        case (state)
          S_DATA: begin
            shreg <= shreg_next;
          end
          S_PARITY: begin
            parity_reg <= serial_in;
          end
          S_STOP: begin
            if (complete) begin
              packet_data   <= shreg;
              parity_bit    <= parity_reg;
              stop_bit      <= stop_final;
              framing_error <= ~stop_final;
              parity_error  <= HAS_PARITY & ((data_xor ^ parity_reg) != ODD_SEL);
              frame_done    <= 1'b1;
              stop_acc      <= 1'b1;
            end else begin
              stop_acc <= stop_final;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Any bit captured means we have left S_DATA or advanced the counter.
  assign busy = (state != S_DATA) || (cnt != '0);

endmodule

// File: tb/tb_uart_rx_frame_sr.sv
// Self-checking bench for uart_rx_frame_sr. Three instances cover the
// default configuration, even parity, and 7-bit MSB-first with 2 stops.
module tb_uart_rx_frame_sr;

  typedef struct packed {
    logic [8:0] data;
    logic       pbit;
    logic       sbit;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] clr;
  logic [2:0] stb;
  logic [2:0] sin;

  logic [7:0] pd0;
  logic [7:0] pd1;
  logic [6:0] pd2;
  logic [2:0] pb;
  logic [2:0] sb;
  logic [2:0] fd;
  logic [2:0] pe;
  logic [2:0] fe;
  logic [2:0] bz;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t exp_q2[$];
  exp_t e0;
  exp_t e1;
  exp_t e2;

  int checks;
  int errors;
  int done_cnt[3];
  int push_cnt[3];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- DUTs ----------------
  uart_rx_frame_sr u_def (
    .clk (clk), .rst (rst), .clear (clr[0]), .shift_strobe (stb[0]),
    .serial_in (sin[0]), .packet_data (pd0), .parity_bit (pb[0]),
    .stop_bit (sb[0]), .frame_done (fd[0]), .parity_error (pe[0]),
    .framing_error (fe[0]), .busy (bz[0])
  );

  uart_rx_frame_sr #(
    .DATA_BITS (8), .PARITY_EN (1), .PARITY_ODD (0), .STOP_BITS (1), .LSB_FIRST (1)
  ) u_par (
    .clk (clk), .rst (rst), .clear (clr[1]), .shift_strobe (stb[1]),
    .serial_in (sin[1]), .packet_data (pd1), .parity_bit (pb[1]),
    .stop_bit (sb[1]), .frame_done (fd[1]), .parity_error (pe[1]),
    .framing_error (fe[1]), .busy (bz[1])
  );

  uart_rx_frame_sr #(
    .DATA_BITS (7), .PARITY_EN (0), .PARITY_ODD (0), .STOP_BITS (2), .LSB_FIRST (0)
  ) u_7b (
    .clk (clk), .rst (rst), .clear (clr[2]), .shift_strobe (stb[2]),
    .serial_in (sin[2]), .packet_data (pd2), .parity_bit (pb[2]),
    .stop_bit (sb[2]), .frame_done (fd[2]), .parity_error (pe[2]),
    .framing_error (fe[2]), .busy (bz[2])
  );

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_frame(input string tag, input exp_t e, input logic [8:0] d,
                           input logic p, input logic s, input logic perr, input logic ferr);
    check({tag, "_data"}, d, e.data);
    check({tag, "_parity_bit"}, {8'd0, p}, {8'd0, e.pbit});
    check({tag, "_stop_bit"}, {8'd0, s}, {8'd0, e.sbit});
    check({tag, "_parity_error"}, {8'd0, perr}, {8'd0, e.perr});
    check({tag, "_framing_error"}, {8'd0, ferr}, {8'd0, e.ferr});
  endtask

  task automatic push_exp(input int inst, input logic [8:0] d, input logic p,
                          input logic s, input logic perr, input logic ferr);
    exp_t e;
    e = '{data: d, pbit: p, sbit: s, perr: perr, ferr: ferr};
    push_cnt[inst]++;
    case (inst)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (fd[0]) begin
      done_cnt[0]++;
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL inst0_unexpected_frame_done: got data %h expected no frame", pd0);
      end else begin
        e0 = exp_q0.pop_front();
        cmp_frame("inst0", e0, {1'b0, pd0}, pb[0], sb[0], pe[0], fe[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (fd[1]) begin
      done_cnt[1]++;
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL inst1_unexpected_frame_done: got data %h expected no frame", pd1);
      end else begin
        e1 = exp_q1.pop_front();
        cmp_frame("inst1", e1, {1'b0, pd1}, pb[1], sb[1], pe[1], fe[1]);
      end
    end
  end

  always @(negedge clk) begin
    if (fd[2]) begin
      done_cnt[2]++;
      if (exp_q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL inst2_unexpected_frame_done: got data %h expected no frame", pd2);
      end else begin
        e2 = exp_q2.pop_front();
        cmp_frame("inst2", e2, {2'b0, pd2}, pb[2], sb[2], pe[2], fe[2]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic strobe_bit(input int inst, input logic b);
    stb[inst] = 1'b1;
    sin[inst] = b;
    @(posedge clk); #1;
    stb[inst] = 1'b0;
    sin[inst] = 1'b1;
  endtask

  // bits/stops are sent bit 0 first. The frame_done/busy checks right
  // after the final stop strobe cover the one-cycle completion latency.
  task automatic send_frame(input int inst, input logic [8:0] bits, input int nbits,
                            input int npar, input logic par, input logic [1:0] stops,
                            input int nstops, input logic rgap);
    logic [11:0] seq;
    int idx;
    int total;
    seq = '0;
    for (int i = 0; i < nbits; i++) seq[i] = bits[i];
    idx = nbits;
    if (npar != 0) begin
      seq[idx] = par;
      idx++;
    end
    for (int j = 0; j < nstops; j++) seq[idx + j] = stops[j];
    total = idx + nstops;
    for (int i = 0; i < total; i++) begin
      strobe_bit(inst, seq[i]);
      if (i == 0) check($sformatf("inst%0d_busy_after_first_bit", inst), {8'd0, bz[inst]}, 9'd1);
      if (i == total - 1) begin
        check($sformatf("inst%0d_frame_done_latency", inst), {8'd0, fd[inst]}, 9'd1);
        check($sformatf("inst%0d_busy_after_done", inst), {8'd0, bz[inst]}, 9'd0);
      end else if (rgap) begin
        idle($urandom_range(0, 3));
      end
    end
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_pd0"}, {1'b0, pd0}, 9'h0FF);
    check({tag, "_parity_bit0"}, {8'd0, pb[0]}, 9'd1);
    check({tag, "_stop_bit0"}, {8'd0, sb[0]}, 9'd1);
    check({tag, "_frame_done0"}, {8'd0, fd[0]}, 9'd0);
    check({tag, "_parity_error0"}, {8'd0, pe[0]}, 9'd0);
    check({tag, "_framing_error0"}, {8'd0, fe[0]}, 9'd0);
    check({tag, "_busy0"}, {8'd0, bz[0]}, 9'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0;
      push_cnt[i] = 0;
    end
    rst = 1'b1;
    clr = '0;
    stb = '0;
    sin = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_reset0("reset");
    check("reset_pd2", {2'b0, pd2}, 9'h07F);
    check("reset_pd1", {1'b0, pd1}, 9'h0FF);

    // Defaults: bits 1,0,1,0,0,1,0,1 + stop 1 -> 0xA5
    push_exp(0, 9'h0A5, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b01, 1, 1'b0);
    idle(3);
    check("hold_pd0_after_A5", {1'b0, pd0}, 9'h0A5);
    check("hold_frame_done0_low", {8'd0, fd[0]}, 9'd0);

    // Bad stop bit, then a good frame clears framing_error
    push_exp(0, 9'h03C, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b00, 1, 1'b0);
    idle(2);
    push_exp(0, 9'h0FF, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 9'h0FF, 8, 0, 1'b0, 2'b01, 1, 1'b1);
    idle(2);

    // Even parity: 0x07 (three ones) parity 1 ok; parity 0 error;
    // 0xC3 (four ones) parity 1 error
    push_exp(1, 9'h007, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(1, 9'h007, 8, 1, 1'b1, 2'b01, 1, 1'b0);
    idle(1);
    push_exp(1, 9'h007, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(1, 9'h007, 8, 1, 1'b0, 2'b01, 1, 1'b1);
    idle(1);
    push_exp(1, 9'h0C3, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(1, 9'h0C3, 8, 1, 1'b1, 2'b01, 1, 1'b0);
    idle(2);

    // 7-bit MSB-first, 2 stops. Bits 0,0,1,1,0,1,0 stops 1,1 -> 7'h1A
    push_exp(2, 9'h01A, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(2, 9'h02C, 7, 0, 1'b0, 2'b11, 2, 1'b1);
    idle(2);
    // Bits 1,1,0,0,1,0,1 stops 1,0 -> 7'h65, framing error
    push_exp(2, 9'h065, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(2, 9'h053, 7, 0, 1'b0, 2'b01, 2, 1'b0);
    idle(2);

    // clear after 4 data strobes: partial frame dropped, outputs held
    for (int i = 0; i < 4; i++) strobe_bit(0, 1'b0);
    check("busy0_before_clear", {8'd0, bz[0]}, 9'd1);
    clr[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    check("busy0_after_clear", {8'd0, bz[0]}, 9'd0);
    check("pd0_held_after_clear", {1'b0, pd0}, 9'h0FF);
    check("frame_done0_after_clear", {8'd0, fd[0]}, 9'd0);
    push_exp(0, 9'h05A, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b01, 1, 1'b1);
    idle(2);

    // rst mid-frame returns everything to reset values
    for (int i = 0; i < 3; i++) strobe_bit(0, 1'b0);
    check("busy0_before_rst", {8'd0, bz[0]}, 9'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset0("midrst");
    check("midrst_pd2", {2'b0, pd2}, 9'h07F);
    check("midrst_framing_error2", {8'd0, fe[2]}, 9'd0);

    // Coincident clear+strobe (strobe with a 0) must be ignored, then
    // two back-to-back frames with random gaps
    clr[0] = 1'b1;
    stb[0] = 1'b1;
    sin[0] = 1'b0;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    stb[0] = 1'b0;
    sin[0] = 1'b1;
    check("busy0_after_clear_strobe", {8'd0, bz[0]}, 9'd0);
    push_exp(0, 9'h012, 1'b1, 1'b1, 1'b0, 1'b0);
    push_exp(0, 9'h034, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 9'h012, 8, 0, 1'b0, 2'b01, 1, 1'b1);
    send_frame(0, 9'h034, 8, 0, 1'b0, 2'b01, 1, 1'b1);
    idle(4);

    // End of run: every expected frame seen exactly once
    check("q0_empty", 9'(exp_q0.size()), 9'd0);
    check("q1_empty", 9'(exp_q1.size()), 9'd0);
    check("q2_empty", 9'(exp_q2.size()), 9'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("inst%0d_frame_done_count", i), 9'(done_cnt[i]), 9'(push_cnt[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
